// File: rtl/core_pkg.sv
// Shared definitions for the ARM-subset 5-stage core.
//   ADDR_W_DEF / INSTR_W_DEF : default address and instruction widths
//   NOP_INSTR                : encoding used for pipeline bubbles (all zeros)
//   fetchStateT              : fetch-stage FSM states
package core_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int INSTR_W_DEF = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  // S_REQ: request outstanding at imem_addr.
  // S_HOLD: instruction parked while the pipe is frozen.
  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetchStateT;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register bank with hold and flush controls.
// The ID/EX register reuses the same pattern.
//   clk, rst_n    : clock, asynchronous active-low reset (clears the bank)
//   hold          : keep current contents
//   flush         : load a bubble {pc 0, NOP, valid 0}; wins over hold
//   dPc/dInstr/dValid : next contents when neither hold nor flush
//   qPc/qInstr/qValid : registered contents
module if_id_reg
  import core_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  dPc,
  input  logic [INSTR_W-1:0] dInstr,
  input  logic               dValid,
  output logic [ADDR_W-1:0]  qPc,
  output logic [INSTR_W-1:0] qInstr,
  output logic               qValid
);

  // NOTE: state flops use non-blocking assignments so every register in the
  // core samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qPc    <= '0;
      qInstr <= INSTR_W'(NOP_INSTR);
      qValid <= 1'b0;
    end else if (flush) begin
      qPc    <= '0;
      qInstr <= INSTR_W'(NOP_INSTR);
      qValid <= 1'b0;
    end else if (!hold) begin
      qPc    <= dPc;
      qInstr <= dInstr;
      qValid <= dValid;
    end
  end

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage plus IF/ID register.
// Owns the PC, fetches over a req/ack handshake and presents
// {pc+4, instr, valid} to ID. Priority per cycle: branch > freeze > normal.
//   clk, rst_n               : clock, asynchronous active-low reset
//   freeze                   : hazard stall, hold PC and IF/ID
//   branch_taken/branch_addr : EX redirect, flushes IF/ID and any parked instr
//   imem_req/imem_addr       : fetch request at the current PC
//   imem_ack/imem_rdata      : instruction return for imem_addr
//   if_id_pc/instr/valid     : IF/ID register contents (pc is PC+4)
//   fetch_busy               : request issued and not yet acknowledged
module if_stage_fetch
  import core_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic               fetch_busy
);

  fetchStateT         state, stateNext;
  logic [ADDR_W-1:0]  pc, pcNext, pcPlus4;
  logic [INSTR_W-1:0] holdQ, holdNext;
  logic               started;
  logic               ackValid;

  logic               idHold, idFlush, idValid;
  logic [ADDR_W-1:0]  idPc;
  logic [INSTR_W-1:0] idInstr;

  // started keeps imem_req low until the first edge after reset release,
  // so the memory never sees a request launched by the reset edge itself.
  assign imem_req   = started && (state == S_REQ);
  assign imem_addr  = pc;
  assign ackValid   = imem_ack && imem_req;
  assign fetch_busy = imem_req && !imem_ack;
  assign pcPlus4    = pc + ADDR_W'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      holdQ   <= INSTR_W'(NOP_INSTR);
      started <= 1'b0;
    end else begin
      state   <= stateNext;
      pc      <= pcNext;
      holdQ   <= holdNext;
      started <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    holdNext  = holdQ;
    idHold    = 1'b1;
    idFlush   = 1'b0;
    idPc      = if_id_pc;
    idInstr   = INSTR_W'(NOP_INSTR);
    idValid   = 1'b0;

    if (branch_taken) begin
      // Redirect drops the parked instruction and any same-cycle return.
      pcNext    = branch_addr;
      stateNext = S_REQ;
      holdNext  = INSTR_W'(NOP_INSTR);
      idFlush   = 1'b1;
      idHold    = 1'b0;
    end else begin
      unique case (state)
        S_REQ: begin
          if (ackValid && !freeze) begin
            pcNext  = pcPlus4;
            idHold  = 1'b0;
            idPc    = pcPlus4;
            idInstr = imem_rdata;
            idValid = 1'b1;
          end else if (ackValid) begin
            // Park the instruction; the advanced pc doubles as its pc+4.
            pcNext    = pcPlus4;
            holdNext  = imem_rdata;
            stateNext = S_HOLD;
          end else if (!freeze) begin
            // No instruction this cycle: bubble, keeping if_id_pc.
            idHold = 1'b0;
          end
        end
        S_HOLD: begin
          if (!freeze) begin
            idHold    = 1'b0;
            idPc      = pc;
            idInstr   = holdQ;
            idValid   = 1'b1;
            stateNext = S_REQ;
          end
        end
        default: stateNext = S_REQ;
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (idHold),
    .flush (idFlush),
    .dPc   (idPc),
    .dInstr(idInstr),
    .dValid(idValid),
    .qPc   (if_id_pc),
    .qInstr(if_id_instr),
    .qValid(if_id_valid)
  );

endmodule

// File: tb/tb_if_stage_fetch.sv
// Testbench for if_stage_fetch: directed scenarios plus randomized traffic,
// all checked against a transaction-level reference model of the fetch stage.
module tb_if_stage_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fetch_busy;

  int nChecks = 0;
  int nPassed = 0;

  // Reference model: architectural view of the stage.
  logic [31:0] mPc;
  logic [31:0] mParked[$];   // at most one instruction parked under freeze
  logic        mRunning;     // request may issue (first edge after reset seen)
  logic [31:0] mIdPc, mIdInstr;
  logic        mIdValid;

  if_stage_fetch #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .fetch_busy  (fetch_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPassed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic modelReq();
    return mRunning && (mParked.size() == 0);
  endfunction

  task automatic modelReset();
    mPc = 32'h0;
    mParked.delete();
    mRunning = 1'b0;
    mIdPc = '0;
    mIdInstr = '0;
    mIdValid = 1'b0;
  endtask

  // Applies one clock edge of the specification's rules to the model.
  task automatic modelEdge();
    logic accepted;
    accepted = imem_ack && modelReq();
    if (branch_taken) begin
      mPc = branch_addr;
      mParked.delete();
      {mIdPc, mIdInstr, mIdValid} = {32'h0, 32'h0, 1'b0};
    end else if (mParked.size() != 0) begin
      if (!freeze) begin
        mIdPc = mPc;
        mIdInstr = mParked.pop_front();
        mIdValid = 1'b1;
      end
    end else if (accepted) begin
      if (freeze) mParked.push_back(imem_rdata);
      else {mIdPc, mIdInstr, mIdValid} = {mPc + 32'd4, imem_rdata, 1'b1};
      mPc = mPc + 32'd4;
    end else if (!freeze) begin
      mIdInstr = '0;
      mIdValid = 1'b0;
    end
    mRunning = 1'b1;
  endtask

  // One cycle: drive inputs, check request side before the edge,
  // then check IF/ID after the edge.
  task automatic step(input logic ack, input logic frz, input logic br,
                      input logic [31:0] baddr, input logic [31:0] rdata);
    imem_ack = ack;
    freeze = frz;
    branch_taken = br;
    branch_addr = baddr;
    imem_rdata = rdata;
    #1;
    check("imem_req", 32'(imem_req), 32'(modelReq()));
    check("imem_addr", imem_addr, mPc);
    check("fetch_busy", 32'(fetch_busy), 32'(modelReq() && !ack));
    @(posedge clk);
    modelEdge();
    #1;
    check("if_id_pc", if_id_pc, mIdPc);
    check("if_id_instr", if_id_instr, mIdInstr);
    check("if_id_valid", 32'(if_id_valid), 32'(mIdValid));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    check("rst_if_id_pc", if_id_pc, 32'h0);
    check("rst_if_id_instr", if_id_instr, 32'h0);
    check("rst_if_id_valid", 32'(if_id_valid), 32'h0);
    check("rst_imem_req", 32'(imem_req), 32'h0);
    {imem_ack, freeze, branch_taken} = 3'b000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    modelReset();
    doReset();

    // 1: ack every cycle from reset release.
    step(1'b1, 1'b0, 1'b0, '0, 32'hA000_0000);   // start edge, no request yet
    for (int i = 0; i < 3; i++) begin
      check("t1_addr", imem_addr, 32'(4 * i));
      step(1'b1, 1'b0, 1'b0, '0, 32'hA000_0000 + 32'(i));
      check("t1_if_id_pc", if_id_pc, 32'(4 * (i + 1)));
      check("t1_valid", 32'(if_id_valid), 32'h1);
    end

    // 2: ack withheld three cycles at pc=8.
    doReset();
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, 32'hB000_0000);
    step(1'b1, 1'b0, 1'b0, '0, 32'hB000_0004);
    for (int i = 0; i < 3; i++) begin
      check("t2_addr", imem_addr, 32'h8);
      step(1'b0, 1'b0, 1'b0, '0, 32'hFFFF_FFFF);
      check("t2_busy_held", 32'(fetch_busy), 32'h1);
      check("t2_valid", 32'(if_id_valid), 32'h0);
    end
    step(1'b1, 1'b0, 1'b0, '0, 32'hB000_0008);
    check("t2_if_id_pc", if_id_pc, 32'hC);
    check("t2_instr", if_id_instr, 32'hB000_0008);

    // 3: freeze with ack at pc=0x10, then release.
    doReset();
    step(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, 32'hC000_0000 + 32'(i));
    check("t3_addr", imem_addr, 32'h10);
    step(1'b1, 1'b1, 1'b0, '0, 32'hE281_1001);
    check("t3_ifid_unchanged_pc", if_id_pc, 32'h10);
    check("t3_ifid_unchanged_instr", if_id_instr, 32'hC000_0003);
    check("t3_req_in_hold", 32'(imem_req), 32'h0);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    check("t3_pc", if_id_pc, 32'h14);
    check("t3_instr", if_id_instr, 32'hE281_1001);
    check("t3_valid", 32'(if_id_valid), 32'h1);

    // 4: branch while in HOLD with freeze high.
    step(1'b1, 1'b1, 1'b0, '0, 32'h1111_1111);
    step(1'b0, 1'b1, 1'b1, 32'h40, '0);
    check("t4_valid", 32'(if_id_valid), 32'h0);
    check("t4_instr", if_id_instr, 32'h0);
    check("t4_addr", imem_addr, 32'h40);
    check("t4_req", 32'(imem_req), 32'h1);

    // 5: branch and ack in the same cycle at pc=0x20.
    step(1'b0, 1'b0, 1'b1, 32'h20, '0);
    step(1'b1, 1'b0, 1'b1, 32'h80, 32'hDEAD_BEEF);
    check("t5_valid", 32'(if_id_valid), 32'h0);
    check("t5_instr", if_id_instr, 32'h0);
    check("t5_addr", imem_addr, 32'h80);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, '0);
    step(1'b1, 1'b0, 1'b0, '0, 32'h5555_AAAA);
    check("wrap_if_id_pc", if_id_pc, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // 6: reset asserted mid-HOLD with a valid instruction in IF/ID.
    step(1'b1, 1'b0, 1'b0, '0, 32'h7777_0000);
    step(1'b1, 1'b1, 1'b0, '0, 32'h7777_0004);
    doReset();
    step(1'b0, 1'b0, 1'b0, '0, '0);
    check("t6_restart_addr", imem_addr, 32'h0);
    step(1'b1, 1'b0, 1'b0, '0, 32'h9999_0000);
    check("t6_restart_pc", if_id_pc, 32'h4);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] target;
      target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
           $urandom_range(0, 15) == 0, target, $urandom);
    end

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
